// File: rtl/ula_bits.sv
// ula_bits: registered ALU built from WIDTH one-bit slices chained by a
// ripple carry (ADD) or ripple borrow (SUB). Logic operations drive the
// chain to zero so carry_out is only ever set by ADD or SUB.

// One bit of the ALU: result bit plus carry/borrow handed to the next slice.
module ula_bits_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] sel,
    output logic       r,
    output logic       cout
);

    // Per-bit operation and carry/borrow generation
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (sel)
            3'b000: begin
                r    = a & b;
                cout = 1'b0;
            end
            3'b001: begin
                r    = a | b;
                cout = 1'b0;
            end
            3'b010: begin
                r    = ~a;
                cout = 1'b0;
            end
            3'b011: begin
                r    = ~(a & b);
                cout = 1'b0;
            end
            3'b100: begin
                // Full adder
                r    = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
            3'b101: begin
                // Full subtractor: a - b - bin, borrow out when the bit underflows
                r    = a ^ b ^ cin;
                cout = (~a & b) | (~(a ^ b) & cin);
            end
            default: begin
                // Reserved codes produce zero on both outputs
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

module ula_bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic [2:0]       seletor,
    output logic [WIDTH-1:0] resultado,
    output logic             carry_out
);

    // chain_s[i] is the carry/borrow entering slice i; chain_s[WIDTH] leaves the MSB
    logic [WIDTH:0]   chain_s;
    logic [WIDTH-1:0] result_s;

    assign chain_s[0] = carry_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_slice
            ula_bits_slice u_slice (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (chain_s[gi]),
                .sel  (seletor),
                .r    (result_s[gi]),
                .cout (chain_s[gi+1])
            );
        end
    endgenerate

    // Output registers: capture the slice results each edge, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            resultado <= {WIDTH{1'b0}};
            carry_out <= 1'b0;
        end else begin
            resultado <= result_s;
            carry_out <= chain_s[WIDTH];
        end
    end

endmodule

// File: tb/tb_ula_bits.sv
// Testbench for ula_bits: directed literal vectors plus randomized stimulus,
// with every registered output compared against an arithmetic reference model.
module tb_ula_bits;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
    logic [2:0]       seletor;
    logic [WIDTH-1:0] resultado;
    logic             carry_out;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_res;
    logic             exp_co;
    logic             exp_valid = 1'b0;

    ula_bits #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .carry_in  (carry_in),
        .seletor   (seletor),
        .resultado (resultado),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry_out, resultado} from plain integer arithmetic
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin,
                                             input logic [2:0] sel);
        int ai, bi, ci, d, m;
        logic [WIDTH:0] out;
        ai = int'(a);
        bi = int'(b);
        ci = int'(cin);
        m  = 1 << WIDTH;
        out = '0;
        case (sel)
            3'd0: out = {1'b0, a & b};
            3'd1: out = {1'b0, a | b};
            3'd2: out = {1'b0, ~a};
            3'd3: out = {1'b0, ~(a & b)};
            3'd4: begin
                d = ai + bi + ci;
                out = {(d >= m) ? 1'b1 : 1'b0, WIDTH'(d % m)};
            end
            3'd5: begin
                d = ai - bi - ci;
                if (d < 0) out = {1'b1, WIDTH'(d + m)};
                else       out = {1'b0, WIDTH'(d)};
            end
            default: out = '0;
        endcase
        return out;
    endfunction

    task automatic check(input string name,
                         input logic [WIDTH-1:0] got_r, input logic [WIDTH-1:0] want_r,
                         input logic got_c, input logic want_c);
        checks++;
        if (got_r !== want_r || got_c !== want_c) begin
            errors++;
            $display("FAIL %s: got resultado=%h carry_out=%b, expected resultado=%h carry_out=%b",
                     name, got_r, got_c, want_r, want_c);
        end
    endtask

    // Model tracks what the output registers must hold after each edge
    always @(posedge clk) begin
        logic [WIDTH:0] m;
        if (rst) m = '0;
        else     m = model(A, B, carry_in, seletor);
        exp_res   <= m[WIDTH-1:0];
        exp_co    <= m[WIDTH];
        exp_valid <= 1'b1;
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) check("model", resultado, exp_res, carry_out, exp_co);
    end

    // Apply one operation, then check the literal expectation one edge later
    task automatic apply_check(input string name, input logic r,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic [2:0] sel,
                               input logic [WIDTH-1:0] want_r, input logic want_c);
        rst = r; A = a; B = b; carry_in = cin; seletor = sel;
        @(posedge clk);
        #1;
        check(name, resultado, want_r, carry_out, want_c);
    endtask

    initial begin
        rst = 1'b1; A = 8'hFF; B = 8'hFF; carry_in = 1'b1; seletor = 3'b100;

        // Reset and release
        apply_check("reset",        1'b1, 8'hFF, 8'hFF, 1'b1, 3'b100, 8'h00, 1'b0);
        apply_check("post_reset",   1'b0, 8'hFF, 8'hFF, 1'b1, 3'b100, 8'hFF, 1'b1);

        // Logic ops
        apply_check("and",          1'b0, 8'hAA, 8'hCC, 1'b0, 3'b000, 8'h88, 1'b0);
        apply_check("or",           1'b0, 8'hAA, 8'hCC, 1'b0, 3'b001, 8'hEE, 1'b0);
        apply_check("not",          1'b0, 8'hAA, 8'hCC, 1'b0, 3'b010, 8'h55, 1'b0);
        apply_check("nand",         1'b0, 8'hAA, 8'hCC, 1'b0, 3'b011, 8'h77, 1'b0);
        apply_check("and_cin1",     1'b0, 8'hAA, 8'hCC, 1'b1, 3'b000, 8'h88, 1'b0);

        // Add
        apply_check("add_c0",       1'b0, 8'h1B, 8'h15, 1'b0, 3'b100, 8'h30, 1'b0);
        apply_check("add_c1",       1'b0, 8'h1B, 8'h15, 1'b1, 3'b100, 8'h31, 1'b0);
        apply_check("add_wrap",     1'b0, 8'hFF, 8'h01, 1'b0, 3'b100, 8'h00, 1'b1);

        // Subtract
        apply_check("sub_plain",    1'b0, 8'h55, 8'h33, 1'b0, 3'b101, 8'h22, 1'b0);
        apply_check("sub_borrow",   1'b0, 8'h20, 8'h40, 1'b1, 3'b101, 8'hDF, 1'b1);
        apply_check("sub_zero",     1'b0, 8'h10, 8'h0F, 1'b1, 3'b101, 8'h00, 1'b0);
        apply_check("sub_eq_bin",   1'b0, 8'h00, 8'h00, 1'b1, 3'b101, 8'hFF, 1'b1);

        // Reserved
        apply_check("rsvd_111",     1'b0, 8'hF0, 8'h0F, 1'b1, 3'b111, 8'h00, 1'b0);
        apply_check("rsvd_110",     1'b0, 8'hF0, 8'h0F, 1'b1, 3'b110, 8'h00, 1'b0);

        // Back-to-back through all codes, reset dropping an in-flight add
        apply_check("b2b_000",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b000, 8'h30, 1'b0);
        apply_check("b2b_001",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b001, 8'hFF, 1'b0);
        apply_check("b2b_010",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b010, 8'h0C, 1'b0);
        apply_check("b2b_011",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b011, 8'hCF, 1'b0);
        apply_check("b2b_100",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b100, 8'h30, 1'b1);
        apply_check("b2b_rst",      1'b1, 8'hF3, 8'h3C, 1'b1, 3'b100, 8'h00, 1'b0);
        apply_check("b2b_101",      1'b0, 8'h3C, 8'hF3, 1'b1, 3'b101, 8'h48, 1'b1);
        apply_check("b2b_110",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b110, 8'h00, 1'b0);
        apply_check("b2b_111",      1'b0, 8'hF3, 8'h3C, 1'b1, 3'b111, 8'h00, 1'b0);

        // Randomized traffic; the every-cycle comparison checks it against the model
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 31) == 0);
            A        = WIDTH'($urandom);
            B        = WIDTH'($urandom);
            carry_in = 1'($urandom_range(0, 1));
            seletor  = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
